food_map_ctrl: RTL and testbench
================================

FOOD_MAP_CTRL -- requirements
Module: food_map_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 50, meaning number of food-map rows (tile rows).
REQ-002 SHALL have parameter COLS, default 80, meaning number of food-map columns; row word width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port disp_en  input  1  display owns the read port this cycle.
REQ-006 SHALL have port disp_row_idx  input  6  row the renderer wants.
REQ-007 SHALL have port disp_row  output  80  food bits for the requested row; bit x = tile column x.
REQ-008 SHALL have port eat_req  input  1  level request to clear one tile.
REQ-009 SHALL have port eat_x  input  7  tile column of the eat request.
REQ-010 SHALL have port eat_y  input  6  tile row of the eat request.
REQ-011 SHALL have port eat_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port eat_hit  output  1  tile held food before the eat; valid with eat_ack.
REQ-013 SHALL have port refill_req  input  1  one-cycle pulse: reload the map from init source.
REQ-014 SHALL have port init_idx  output  6  row address to the external map ROM (1-cycle read latency).
REQ-015 SHALL have port init_row  input  80  ROM row data; 1 = tile starts with food.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-017 SHALL have port food_count  output  12  remaining food tiles.
REQ-018 SHALL have port all_eaten  output  1  map valid and food_count == 0.

Function
REQ-019 SHALL hold a ROWS x COLS storage array with one read port and one write port; read-during-write to the same row returns the old data.
REQ-020 SHALL give the read port to the display whenever disp_en=1; on each such cycle, disp_row SHALL present the row at disp_row_idx on the next clock edge (1-cycle latency).
REQ-021 SHALL hold disp_row at its last value on cycles where disp_en=0.
REQ-022 SHALL drive disp_row all-zero for disp_row_idx >= ROWS, and while map_valid=0.
REQ-023 SHALL implement the FSM states IDLE, FILL, EAT_RD, EAT_CHK, EAT_WR.
REQ-024 SHALL, in IDLE with refill_req (or a latched pending refill), enter FILL; refill SHALL take priority over eat_req.
REQ-025 SHALL, in IDLE with eat_req=1 and no pending refill, enter EAT_RD.
REQ-026 SHALL, in FILL, drive init_idx = 0,1,...,ROWS-1 on consecutive cycles and write init_row into row init_idx-1 one cycle later, for a total of ROWS+1 cycles.
REQ-027 SHALL, in FILL, clear food_count to 0 on entry, add popcount(init_row) on each write cycle, set map_valid=1 on the last write, then return to IDLE.
REQ-028 SHALL, in EAT_RD, wait while disp_en=1; on the first cycle with disp_en=0 it SHALL issue the read of row eat_y and go to EAT_CHK.
REQ-029 SHALL, in EAT_CHK, sample bit eat_x of the read data as hit and go to EAT_WR.
REQ-030 SHALL, in EAT_WR, write the row with bit eat_x cleared if hit, decrement food_count if hit, pulse eat_ack with eat_hit=hit, and return to IDLE.
REQ-031 SHALL, when eat_x >= COLS or eat_y >= ROWS, go from EAT_RD straight to EAT_WR with hit=0, perform no write, and still pulse eat_ack.
REQ-032 SHALL treat the eat handshake as follows: the requester holds eat_req, eat_x and eat_y stable until eat_ack; eat_req=1 in the cycle after eat_ack starts a new request.
REQ-033 SHALL latch a refill_req that arrives in any non-IDLE state as pending; the current operation completes first and FILL follows.
REQ-034 SHALL never let food_count underflow; a decrement at 0 is suppressed.

Reset
REQ-035 SHALL, while rst_n=0, set: state=FILL-pending, disp_row=0, eat_ack=0, eat_hit=0, init_idx=0, food_count=0, map_valid=0, busy=1, all_eaten=0.
REQ-036 SHALL, after rst_n deasserts, run FILL automatically without needing refill_req; array contents are not reset.
REQ-037 SHALL, on a reset asserted mid-operation, abort it (no ack) and restart FILL after release.

Verification
REQ-038 SHALL cover: ROM rows all 0x...FF (80 ones) after reset -> busy for 51 cycles, then food_count=4000, all_eaten=0, disp_row_idx=3 gives all-ones next cycle.
REQ-039 SHALL cover: eat (x=5,y=3) with disp_en=0 -> eat_ack 3 cycles after eat_req with eat_hit=1, food_count=3999, row 3 bit 5 = 0; repeating the same eat -> eat_hit=0, count unchanged.
REQ-040 SHALL cover: eat_req while disp_en=1 for 20 cycles -> no ack during those cycles; ack 3 cycles after disp_en falls; display reads are unaffected.
REQ-041 SHALL cover: eat (x=80,y=10) -> ack with eat_hit=0, no row changes; and disp_row_idx=55 -> disp_row=0.
REQ-042 SHALL cover: refill_req and eat_req in the same IDLE cycle -> FILL first (51 cycles), then eat completes with hit per the reloaded map.
REQ-043 SHALL cover: single-one ROM map, eat that tile -> food_count=0, all_eaten=1; rst_n pulsed during EAT_CHK -> no ack, FILL restarts.

Source files
------------

// File: rtl/food_map_ctrl_if.sv
// food_map_ctrl_if -- bus bundle for the food-map controller.
//   display side : disp_en, disp_row_idx -> disp_row (1-cycle read latency)
//   eat side     : eat_req/eat_x/eat_y -> eat_ack pulse with eat_hit
//   init side    : refill_req; init_idx -> external ROM -> init_row
//   status       : busy, food_count, all_eaten
// master = requester/ROM side, slave = the controller.
interface food_map_ctrl_if #(
    parameter int COLS = 80
);
    logic            disp_en;
    logic [5:0]      disp_row_idx;
    logic [COLS-1:0] disp_row;

    logic            eat_req;
    logic [6:0]      eat_x;
    logic [5:0]      eat_y;
    logic            eat_ack;
    logic            eat_hit;

    logic            refill_req;
    logic [5:0]      init_idx;
    logic [COLS-1:0] init_row;

    logic            busy;
    logic [11:0]     food_count;
    logic            all_eaten;

    modport master (
        output disp_en, disp_row_idx, eat_req, eat_x, eat_y, refill_req, init_row,
        input  disp_row, eat_ack, eat_hit, init_idx, busy, food_count, all_eaten
    );

    modport slave (
        input  disp_en, disp_row_idx, eat_req, eat_x, eat_y, refill_req, init_row,
        output disp_row, eat_ack, eat_hit, init_idx, busy, food_count, all_eaten
    );
endinterface

// File: rtl/food_map_ctrl.sv
// food_map_ctrl -- ROWS x COLS food bitmap with a display read port, an
// eat (read-check-clear) engine and a reload sequencer fed by an external ROM.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; a FILL starts automatically on release
//   bus   : food_map_ctrl_if.slave (display, eat handshake, ROM, status)
module food_map_ctrl #(
    parameter int ROWS = 50,
    parameter int COLS = 80
) (
    input  logic clk,
    input  logic rst_n,
    food_map_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, FILL, EAT_RD, EAT_CHK, EAT_WR} state_t;

    localparam logic [6:0] ROWS_W = 7'(ROWS);
    localparam logic [7:0] COLS_W = 8'(COLS);

    state_t          state;
    logic [6:0]      fill_cnt;
    logic [5:0]      init_addr;
    logic [11:0]     food_left;
    logic            map_valid;
    logic            pending;
    logic [COLS-1:0] eat_row;
    logic            ack;
    logic            hit;
    logic [COLS-1:0] disp_data;

    logic [COLS-1:0] mem [ROWS];

    logic [5:0]      rd_addr;
    logic [COLS-1:0] rd_data;
    logic            eat_in_range;
    logic [COLS-1:0] clr_mask;
    logic            wr_en;
    logic [5:0]      wr_addr;
    logic [COLS-1:0] wr_data;

    function automatic logic [11:0] popcount(input logic [COLS-1:0] v);
        logic [11:0] n;
        n = '0;
        for (int unsigned i = 0; i < COLS; i++) n = n + 12'(v[i]);
        return n;
    endfunction

    // Single read port: the display wins whenever it asserts disp_en.
    assign rd_addr = bus.disp_en ? bus.disp_row_idx : bus.eat_y;

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < ROWS_W) rd_data = mem[rd_addr];
    end

    assign eat_in_range = ({1'b0, bus.eat_y} < ROWS_W) && ({1'b0, bus.eat_x} < COLS_W);

    always_comb begin
        clr_mask = '0;
        if (eat_in_range) clr_mask[bus.eat_x] = 1'b1;
    end

    // FILL writes row fill_cnt-1 (ROM data lags init_idx by one cycle);
    // EAT_WR only writes when a food bit is actually being cleared.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.eat_y;
        wr_data = eat_row & ~clr_mask;
        if (state == FILL) begin
            wr_en   = (fill_cnt != 7'd0);
            wr_addr = 6'(fill_cnt - 7'd1);
            wr_data = bus.init_row;
        end else if (state == EAT_WR) begin
            wr_en   = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            fill_cnt  <= '0;
            init_addr <= '0;
            food_left <= '0;
            map_valid <= 1'b0;
            pending   <= 1'b0;
            eat_row   <= '0;
            ack       <= 1'b0;
            hit       <= 1'b0;
            disp_data <= '0;
        end else begin
            ack <= 1'b0;
            hit <= 1'b0;

            if (bus.disp_en) disp_data <= map_valid ? rd_data : '0;

            if (bus.refill_req && state != IDLE) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.refill_req || pending) begin
                        state     <= FILL;
                        pending   <= 1'b0;
                        fill_cnt  <= '0;
                        init_addr <= '0;
                        food_left <= '0;
                        map_valid <= 1'b0;
                    end else if (bus.eat_req) begin
                        state <= EAT_RD;
                    end
                end
                FILL: begin
                    if (fill_cnt != 7'd0) food_left <= food_left + popcount(bus.init_row);
                    if (fill_cnt == ROWS_W) begin
                        map_valid <= 1'b1;
                        init_addr <= '0;
                        state     <= IDLE;
                    end else begin
                        fill_cnt  <= fill_cnt + 7'd1;
                        init_addr <= (fill_cnt + 7'd1 < ROWS_W) ? 6'(fill_cnt + 7'd1) : 6'd0;
                    end
                end
                EAT_RD: begin
                    if (!bus.disp_en) begin
                        if (eat_in_range) begin
                            eat_row <= rd_data;
                            state   <= EAT_CHK;
                        end else begin
                            ack   <= 1'b1;
                            state <= EAT_WR;
                        end
                    end
                end
                EAT_CHK: begin
                    // ack/hit are raised here so they are visible during EAT_WR.
                    ack   <= 1'b1;
                    hit   <= eat_row[bus.eat_x];
                    state <= EAT_WR;
                end
                EAT_WR: begin
                    if (hit && food_left != 12'd0) food_left <= food_left - 12'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.disp_row   = disp_data;
    assign bus.eat_ack    = ack;
    assign bus.eat_hit    = hit;
    assign bus.init_idx   = init_addr;
    assign bus.busy       = (state != IDLE);
    assign bus.food_count = food_left;
    assign bus.all_eaten  = map_valid && (food_left == 12'd0);

endmodule

// File: tb/tb_food_map_ctrl.sv
// tb_food_map_ctrl -- directed bench for food_map_ctrl with a 1-cycle-latency
// ROM model on init_idx/init_row.
module tb_food_map_ctrl;
    localparam int ROWS = 50;
    localparam int COLS = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    food_map_ctrl_if #(.COLS(COLS)) bus ();

    food_map_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [COLS-1:0] rom [ROWS];
    always @(posedge clk) bus.init_row <= rom[bus.init_idx];

    int vectors = 0;
    int misc = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misc++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fill(output int cyc, output int acks, output int idx1, output int idx49);
        cyc = 0; acks = 0; idx1 = -1; idx49 = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.eat_ack) acks++;
            if (!bus.busy) break;
            if (cyc == 1) idx1 = int'(bus.init_idx);
            if (cyc == 49) idx49 = int'(bus.init_idx);
            cyc++;
        end
    endtask

    task automatic disp_read(input logic [5:0] idx, output logic [COLS-1:0] row);
        @(posedge clk); #1;
        bus.disp_en = 1'b1;
        bus.disp_row_idx = idx;
        @(posedge clk); #1;
        bus.disp_en = 1'b0;
        @(negedge clk);
        row = bus.disp_row;
    endtask

    // lat = number of cycles from the request cycle to the ack cycle, -1 on timeout
    task automatic do_eat(input logic [6:0] x, input logic [5:0] y, input logic with_refill,
                          input int budget, output int lat, output logic h);
        @(posedge clk); #1;
        bus.eat_x = x;
        bus.eat_y = y;
        bus.eat_req = 1'b1;
        bus.refill_req = with_refill;
        lat = -1;
        h = 1'bx;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.eat_ack) begin
                lat = n;
                h = bus.eat_hit;
                break;
            end
            if (n == 0) begin
                @(posedge clk); #1;
                bus.refill_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.eat_req = 1'b0;
        bus.refill_req = 1'b0;
    endtask

    initial begin
        int lat, cyc, acks, idx1, idx49;
        logic h;
        logic [COLS-1:0] row, ones, r3, r7, alt, alt3;

        ones = '1;
        r3 = ones; r3[5] = 1'b0;
        r7 = ones; r7[10] = 1'b0;
        alt = 80'hAAAA_AAAA_AAAA_AAAA_AAAA;
        alt3 = 80'hAAAA_AAAA_AAAA_AAAA_AA8A;

        bus.disp_en = 1'b0;
        bus.disp_row_idx = '0;
        bus.eat_req = 1'b0;
        bus.eat_x = '0;
        bus.eat_y = '0;
        bus.refill_req = 1'b0;
        for (int r = 0; r < ROWS; r++) rom[r] = '1;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_disp_row", bus.disp_row, 80'd0);
        check("rst_eat_ack", 80'(bus.eat_ack), 80'd0);
        check("rst_eat_hit", 80'(bus.eat_hit), 80'd0);
        check("rst_init_idx", 80'(bus.init_idx), 80'd0);
        check("rst_food_count", 80'(bus.food_count), 80'd0);
        check("rst_busy", 80'(bus.busy), 80'd1);
        check("rst_all_eaten", 80'(bus.all_eaten), 80'd0);

        // automatic fill after release
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_fill(cyc, acks, idx1, idx49);
        check("fill_busy_cycles", 80'(cyc), 80'd51);
        check("fill_init_idx1", 80'(idx1), 80'd1);
        check("fill_init_idx49", 80'(idx49), 80'd49);
        check("fill_count", 80'(bus.food_count), 80'd4000);
        check("fill_all_eaten", 80'(bus.all_eaten), 80'd0);
        disp_read(6'd3, row);
        check("disp_row3", row, ones);
        disp_read(6'd49, row);
        check("disp_row49", row, ones);

        // eat with display idle
        do_eat(7'd5, 6'd3, 1'b0, 10, lat, h);
        check("eat1_lat", 80'(lat), 80'd3);
        check("eat1_hit", 80'(h), 80'd1);
        check("eat1_count", 80'(bus.food_count), 80'd3999);
        disp_read(6'd3, row);
        check("eat1_row3", row, r3);
        do_eat(7'd5, 6'd3, 1'b0, 10, lat, h);
        check("eat2_lat", 80'(lat), 80'd3);
        check("eat2_hit", 80'(h), 80'd0);
        check("eat2_count", 80'(bus.food_count), 80'd3999);

        // eat stalled by the display for 20 cycles
        @(posedge clk); #1;
        bus.disp_en = 1'b1;
        bus.eat_x = 7'd10;
        bus.eat_y = 6'd7;
        bus.eat_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.disp_row_idx = (i % 2 == 0) ? 6'd7 : 6'd3;
            @(negedge clk);
            check("hold_no_ack", 80'(bus.eat_ack), 80'd0);
            if (i > 0) check("hold_disp", bus.disp_row, (i % 2 == 1) ? ones : r3);
            @(posedge clk); #1;
        end
        bus.disp_en = 1'b0;
        lat = -1;
        h = 1'bx;
        // counted from the last cycle the display held the port
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.eat_ack) begin
                lat = n;
                h = bus.eat_hit;
                break;
            end
        end
        @(posedge clk); #1;
        bus.eat_req = 1'b0;
        check("hold_lat", 80'(lat), 80'd3);
        check("hold_hit", 80'(h), 80'd1);
        check("hold_count", 80'(bus.food_count), 80'd3998);
        disp_read(6'd7, row);
        check("hold_row7", row, r7);

        // out-of-range eats and display index
        do_eat(7'd80, 6'd10, 1'b0, 10, lat, h);
        check("oor_x_lat", 80'(lat), 80'd2);
        check("oor_x_hit", 80'(h), 80'd0);
        do_eat(7'd0, 6'd60, 1'b0, 10, lat, h);
        check("oor_y_lat", 80'(lat), 80'd2);
        check("oor_y_hit", 80'(h), 80'd0);
        check("oor_count", 80'(bus.food_count), 80'd3998);
        disp_read(6'd10, row);
        check("oor_row10", row, ones);
        disp_read(6'd55, row);
        check("disp_row55", row, 80'd0);

        // refill and eat in the same IDLE cycle: fill wins, eat sees new map
        for (int r = 0; r < ROWS; r++) rom[r] = alt;
        do_eat(7'd5, 6'd3, 1'b1, 100, lat, h);
        check("refill_eat_lat", 80'(lat), 80'd55);
        check("refill_eat_hit", 80'(h), 80'd1);
        check("refill_eat_count", 80'(bus.food_count), 80'd1999);
        disp_read(6'd3, row);
        check("refill_row3", row, alt3);

        // single food tile
        for (int r = 0; r < ROWS; r++) rom[r] = '0;
        rom[20] = 80'h8000_0000_0000_0000_0000;
        @(posedge clk); #1;
        bus.refill_req = 1'b1;
        @(posedge clk); #1;
        bus.refill_req = 1'b0;
        disp_read(6'd20, row);
        check("fill_disp_zero", row, 80'd0);
        wait_fill(cyc, acks, idx1, idx49);
        check("one_count", 80'(bus.food_count), 80'd1);
        check("one_all_eaten", 80'(bus.all_eaten), 80'd0);
        do_eat(7'd79, 6'd20, 1'b0, 10, lat, h);
        check("one_eat_hit", 80'(h), 80'd1);
        check("one_eat_count", 80'(bus.food_count), 80'd0);
        check("one_all_eaten_1", 80'(bus.all_eaten), 80'd1);
        do_eat(7'd79, 6'd20, 1'b0, 10, lat, h);
        check("underflow_hit", 80'(h), 80'd0);
        check("underflow_count", 80'(bus.food_count), 80'd0);

        // refill arriving mid-eat is deferred until the eat completes
        @(posedge clk); #1;
        bus.eat_x = 7'd0;
        bus.eat_y = 6'd0;
        bus.eat_req = 1'b1;
        @(posedge clk); #1;
        bus.refill_req = 1'b1;
        @(posedge clk); #1;
        bus.refill_req = 1'b0;
        lat = -1;
        h = 1'bx;
        for (int n = 2; n <= 10; n++) begin
            @(negedge clk);
            if (bus.eat_ack) begin
                lat = n;
                h = bus.eat_hit;
                break;
            end
        end
        @(posedge clk); #1;
        bus.eat_req = 1'b0;
        check("pend_lat", 80'(lat), 80'd3);
        check("pend_hit", 80'(h), 80'd0);
        @(negedge clk);
        @(negedge clk);
        check("pend_busy", 80'(bus.busy), 80'd1);
        wait_fill(cyc, acks, idx1, idx49);
        check("pend_count", 80'(bus.food_count), 80'd1);

        // reset during EAT_CHK aborts the eat and restarts the fill
        @(posedge clk); #1;
        bus.eat_x = 7'd79;
        bus.eat_y = 6'd20;
        bus.eat_req = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.eat_req = 1'b0;
        #1;
        check("abort_ack", 80'(bus.eat_ack), 80'd0);
        check("abort_busy", 80'(bus.busy), 80'd1);
        check("abort_count", 80'(bus.food_count), 80'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_fill(cyc, acks, idx1, idx49);
        check("abort_fill_cycles", 80'(cyc), 80'd51);
        check("abort_no_ack", 80'(acks), 80'd0);
        check("abort_refill_count", 80'(bus.food_count), 80'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
